// File: rtl/id_ex_stage_if.sv
// Bundle of ID-stage inputs, ID/EX register outputs and hazard/counter outputs for id_ex_stage.
// master = the ID side of the pipeline, slave = the ID/EX stage itself.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [4:0]        ID_RsAddr;
  logic [4:0]        ID_RtAddr;
  logic [4:0]        ID_RdAddr;
  logic              ID_UsesRs;
  logic              ID_UsesRt;
  logic [DATA_W-1:0] ID_RsData;
  logic [DATA_W-1:0] ID_RtData;
  logic [DATA_W-1:0] ID_Imm;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              ID_MemWrite;
  logic              ID_MemtoReg;
  logic              ID_ALUSrc;
  logic [3:0]        ID_ALUOp;
  logic              ID_Valid;
  logic              Flush;

  logic [4:0]        ID_EX_RsAddr;
  logic [4:0]        ID_EX_RtAddr;
  logic [4:0]        ID_EX_RdAddr;
  logic [DATA_W-1:0] ID_EX_RsData;
  logic [DATA_W-1:0] ID_EX_RtData;
  logic [DATA_W-1:0] ID_EX_Imm;
  logic              ID_EX_RegWrite;
  logic              ID_EX_MemRead;
  logic              ID_EX_MemWrite;
  logic              ID_EX_MemtoReg;
  logic              ID_EX_ALUSrc;
  logic [3:0]        ID_EX_ALUOp;
  logic              ID_EX_Valid;

  logic              Stall;
  logic              PCWrite;
  logic              IF_ID_Write;
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  FlushCount;

  modport master (
    output ID_RsAddr, ID_RtAddr, ID_RdAddr, ID_UsesRs, ID_UsesRt,
           ID_RsData, ID_RtData, ID_Imm,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
           ID_ALUOp, ID_Valid, Flush,
    input  ID_EX_RsAddr, ID_EX_RtAddr, ID_EX_RdAddr,
           ID_EX_RsData, ID_EX_RtData, ID_EX_Imm,
           ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
           ID_EX_ALUSrc, ID_EX_ALUOp, ID_EX_Valid,
           Stall, PCWrite, IF_ID_Write, StallCount, FlushCount
  );

  modport slave (
    input  ID_RsAddr, ID_RtAddr, ID_RdAddr, ID_UsesRs, ID_UsesRt,
           ID_RsData, ID_RtData, ID_Imm,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
           ID_ALUOp, ID_Valid, Flush,
    output ID_EX_RsAddr, ID_EX_RtAddr, ID_EX_RdAddr,
           ID_EX_RsData, ID_EX_RtData, ID_EX_Imm,
           ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
           ID_EX_ALUSrc, ID_EX_ALUOp, ID_EX_Valid,
           Stall, PCWrite, IF_ID_Write, StallCount, FlushCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS pipeline with load-use stall, branch flush
// and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  logic [4:0]        r_rs_addr;
  logic [4:0]        r_rt_addr;
  logic [4:0]        r_rd_addr;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_memto_reg;
  logic              r_alu_src;
  logic [3:0]        r_alu_op;
  logic              r_valid;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_dep_rs;
  logic w_dep_rt;
  logic w_hazard;
  logic w_stall;
  logic w_bubble;

  // A real load in EX writing a nonzero register that ID reads forces one bubble.
  assign w_dep_rs = bus.ID_UsesRs && (bus.ID_RsAddr == r_rd_addr);
  assign w_dep_rt = bus.ID_UsesRt && (bus.ID_RtAddr == r_rd_addr);
  assign w_hazard = r_mem_read && r_valid && (r_rd_addr != 5'd0) && bus.ID_Valid &&
                    (w_dep_rs || w_dep_rt);
  assign w_stall  = w_hazard && !bus.Flush;
  assign w_bubble = bus.Flush || w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_memto_reg <= 1'b0;
      r_alu_src   <= 1'b0;
      r_alu_op    <= '0;
      r_valid     <= 1'b0;
    end else if (w_bubble) begin
      // Zeroed addresses keep the forwarding unit from ever matching a bubble.
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_memto_reg <= 1'b0;
      r_alu_src   <= 1'b0;
      r_alu_op    <= '0;
      r_valid     <= 1'b0;
    end else begin
      r_rs_addr   <= bus.ID_RsAddr;
      r_rt_addr   <= bus.ID_RtAddr;
      r_rd_addr   <= bus.ID_RdAddr;
      r_rs_data   <= bus.ID_RsData;
      r_rt_data   <= bus.ID_RtData;
      r_imm       <= bus.ID_Imm;
      r_reg_write <= bus.ID_RegWrite;
      r_mem_read  <= bus.ID_MemRead;
      r_mem_write <= bus.ID_MemWrite;
      r_memto_reg <= bus.ID_MemtoReg;
      r_alu_src   <= bus.ID_ALUSrc;
      r_alu_op    <= bus.ID_ALUOp;
      r_valid     <= bus.ID_Valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (bus.Flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.ID_EX_RsAddr   = r_rs_addr;
  assign bus.ID_EX_RtAddr   = r_rt_addr;
  assign bus.ID_EX_RdAddr   = r_rd_addr;
  assign bus.ID_EX_RsData   = r_rs_data;
  assign bus.ID_EX_RtData   = r_rt_data;
  assign bus.ID_EX_Imm      = r_imm;
  assign bus.ID_EX_RegWrite = r_reg_write;
  assign bus.ID_EX_MemRead  = r_mem_read;
  assign bus.ID_EX_MemWrite = r_mem_write;
  assign bus.ID_EX_MemtoReg = r_memto_reg;
  assign bus.ID_EX_ALUSrc   = r_alu_src;
  assign bus.ID_EX_ALUOp    = r_alu_op;
  assign bus.ID_EX_Valid    = r_valid;
  assign bus.Stall          = w_stall;
  assign bus.PCWrite        = !w_stall;
  assign bus.IF_ID_Write    = !w_stall;
  assign bus.StallCount     = r_stall_cnt;
  assign bus.FlushCount     = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against an instruction-level reference model.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0]        rs, rt, rd;
    logic [DATA_W-1:0] rsd, rtd, imm;
    logic              regw, memr, memw, m2r, alusrc;
    logic [3:0]        aluop;
    logic              valid;
  } ex_t;

  typedef struct packed {
    ex_t  f;
    logic uses_rs, uses_rt;
  } id_t;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [$bits(ex_t)-1:0] exp_q[$];
  ex_t m_ex;
  int  m_stalls;
  int  m_flushes;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ex_t obs_ex();
    ex_t o;
    o.rs = bus.ID_EX_RsAddr;     o.rt = bus.ID_EX_RtAddr;     o.rd = bus.ID_EX_RdAddr;
    o.rsd = bus.ID_EX_RsData;    o.rtd = bus.ID_EX_RtData;    o.imm = bus.ID_EX_Imm;
    o.regw = bus.ID_EX_RegWrite; o.memr = bus.ID_EX_MemRead;  o.memw = bus.ID_EX_MemWrite;
    o.m2r = bus.ID_EX_MemtoReg;  o.alusrc = bus.ID_EX_ALUSrc; o.aluop = bus.ID_EX_ALUOp;
    o.valid = bus.ID_EX_Valid;
    return o;
  endfunction

  // reference: does the instruction in ID read the register a real load in EX is about to produce?
  function automatic logic load_use(input ex_t ex, input id_t id);
    logic reads_it;
    reads_it = (id.uses_rs && id.f.rs == ex.rd) || (id.uses_rt && id.f.rt == ex.rd);
    return ex.valid && ex.memr && ex.rd != 5'd0 && id.f.valid && reads_it;
  endfunction

  function automatic int sat(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  function automatic id_t mk(input int rs, input int rt, input int rd, input logic ur,
                             input logic ut, input logic regw, input logic memr,
                             input logic memw, input logic m2r, input logic alusrc,
                             input int aluop);
    id_t i;
    i.f.rs = 5'(rs); i.f.rt = 5'(rt); i.f.rd = 5'(rd);
    i.f.rsd = $urandom; i.f.rtd = $urandom; i.f.imm = $urandom;
    i.f.regw = regw; i.f.memr = memr; i.f.memw = memw; i.f.m2r = m2r; i.f.alusrc = alusrc;
    i.f.aluop = 4'(aluop); i.f.valid = 1'b1;
    i.uses_rs = ur; i.uses_rt = ut;
    return i;
  endfunction

  function automatic id_t lw(input int rd, input int base);
    return mk(base, rd, rd, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0);
  endfunction

  function automatic id_t add(input int rd, input int rs, input int rt);
    return mk(rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
  endfunction

  function automatic id_t rand_id();
    id_t i;
    i = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15));
    i.f.valid = ($urandom_range(0, 7) != 0);
    return i;
  endfunction

  // driver
  task automatic drive(input id_t id, input logic flush);
    bus.ID_RsAddr = id.f.rs;       bus.ID_RtAddr = id.f.rt;       bus.ID_RdAddr = id.f.rd;
    bus.ID_UsesRs = id.uses_rs;    bus.ID_UsesRt = id.uses_rt;
    bus.ID_RsData = id.f.rsd;      bus.ID_RtData = id.f.rtd;      bus.ID_Imm = id.f.imm;
    bus.ID_RegWrite = id.f.regw;   bus.ID_MemRead = id.f.memr;    bus.ID_MemWrite = id.f.memw;
    bus.ID_MemtoReg = id.f.m2r;    bus.ID_ALUSrc = id.f.alusrc;   bus.ID_ALUOp = id.f.aluop;
    bus.ID_Valid = id.f.valid;     bus.Flush = flush;
  endtask

  // One pipeline cycle: called at posedge+1, returns at the next posedge+1.
  task automatic apply(input id_t id, input logic flush);
    logic exp_stall;
    ex_t  nxt;
    drive(id, flush);
    @(negedge clk);
    exp_stall = load_use(m_ex, id) && !flush;
    check("stall", 128'(bus.Stall), 128'(exp_stall));
    check("pcwrite", 128'(bus.PCWrite), 128'(!exp_stall));
    check("ifid_write", 128'(bus.IF_ID_Write), 128'(!exp_stall));
    nxt = (flush || exp_stall) ? '0 : id.f;
    exp_q.push_back(nxt);
    if (exp_stall) m_stalls++;
    if (flush) m_flushes++;
    @(posedge clk);
    #1;
    m_ex = nxt;
    check("id_ex", 128'(obs_ex()), 128'(exp_q.pop_front()));
    check("stall_cnt", 128'(bus.StallCount), 128'(sat(m_stalls)));
    check("flush_cnt", 128'(bus.FlushCount), 128'(sat(m_flushes)));
  endtask

  task automatic model_reset();
    m_ex = '0;
    m_stalls = 0;
    m_flushes = 0;
    exp_q.delete();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ex"}, 128'(obs_ex()), 128'(0));
    check({tag, "_stall"}, 128'(bus.Stall), 128'(0));
    check({tag, "_pcwrite"}, 128'(bus.PCWrite), 128'(1));
    check({tag, "_cnts"}, 128'({bus.StallCount, bus.FlushCount}), 128'(0));
  endtask

  // Holds reset for a few edges under random inputs; returns at posedge+1 with rst_n released.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) begin
      drive(rand_id(), 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
      check_cleared("in_reset");
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(rand_id(), 1'b0);
    @(posedge clk);
    #1;
    do_reset();

    // first instruction after reset
    apply(add(3, 1, 2), 1'b0);
    check("add_rd", 128'(bus.ID_EX_RdAddr), 128'(3));
    check("add_regw_valid", 128'({bus.ID_EX_RegWrite, bus.ID_EX_Valid}), 128'(2'b11));

    // load-use: lw $5 then dependent add stalls exactly once
    do_reset();
    apply(lw(5, 1), 1'b0);
    apply(add(6, 5, 2), 1'b0);
    check("lu_bubble", 128'({bus.ID_EX_RegWrite, bus.ID_EX_RdAddr}), 128'(0));
    apply(add(6, 5, 2), 1'b0);
    check("lu_captured_rd", 128'(bus.ID_EX_RdAddr), 128'(6));
    check("lu_stall_cnt", 128'(bus.StallCount), 128'(1));

    // store after load reading the loaded register as rt
    apply(lw(4, 2), 1'b0);
    apply(mk(3, 4, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0), 1'b0);
    check("sw_stall_cnt", 128'(bus.StallCount), 128'(2));

    // no hazard: independent add, and dependence through $0
    do_reset();
    apply(lw(5, 1), 1'b0);
    apply(add(6, 7, 8), 1'b0);
    apply(lw(0, 1), 1'b0);
    apply(add(6, 0, 2), 1'b0);
    check("nohaz_stall_cnt", 128'(bus.StallCount), 128'(0));

    // back-to-back loads: only the immediately preceding load matters
    apply(lw(5, 1), 1'b0);
    apply(lw(7, 2), 1'b0);
    apply(add(6, 5, 2), 1'b0);
    check("b2b_stall_cnt", 128'(bus.StallCount), 128'(0));

    // flush wins over a simultaneous load-use hazard
    do_reset();
    apply(lw(5, 1), 1'b0);
    apply(add(6, 5, 2), 1'b1);
    check("flush_cnts", 128'({bus.FlushCount, bus.StallCount}), 128'({8'd1, 8'd0}));
    check("flush_bubble_valid", 128'(bus.ID_EX_Valid), 128'(0));

    // saturation: a self-dependent load stalls every other cycle
    do_reset();
    for (int i = 0; i < 1200 && m_stalls < CNT_MAX + 4; i++) apply(lw(5, 5), 1'b0);
    check("stall_sat", 128'(bus.StallCount), 128'(CNT_MAX));
    for (int i = 0; i < CNT_MAX + 3; i++) apply(rand_id(), 1'b1);
    check("flush_sat", 128'(bus.FlushCount), 128'(CNT_MAX));

    // asynchronous reset while a stall is pending
    do_reset();
    apply(lw(5, 1), 1'b0);
    drive(add(6, 5, 2), 1'b0);
    #2;
    check("pre_areset_stall", 128'(bus.Stall), 128'(1));
    rst_n = 1'b0;
    #1;
    model_reset();
    check_cleared("areset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(add(6, 5, 2), 1'b0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      id_t r;
      r = rand_id();
      // bias toward dependences on whatever EX holds
      if ($urandom_range(0, 2) == 0) r.f.rs = m_ex.rd;
      if ($urandom_range(0, 3) == 0) r.f.rt = m_ex.rd;
      apply(r, 1'($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
